// File: rtl/tdm_demux_if.sv
// Bus between a TDM line source and the two-channel demultiplexer.
interface tdm_demux_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNTW  = 8
);
  logic [WIDTH-1:0] d;
  logic             en;
  logic             sync;
  logic [WIDTH-1:0] z0;
  logic [WIDTH-1:0] z1;
  logic             v0;
  logic             v1;
  logic             frame;
  logic             err;
  logic             lock;
  logic [CNTW-1:0]  fcnt;
  logic [CNTW-1:0]  ecnt;

  modport master (
    output d, en, sync,
    input  z0, z1, v0, v1, frame, err, lock, fcnt, ecnt
  );

  modport slave (
    input  d, en, sync,
    output z0, z1, v0, v1, frame, err, lock, fcnt, ecnt
  );
endinterface

// File: rtl/tdm_demux.sv
// Two-channel TDM demultiplexer with frame alignment tracking,
// sync-error detection and frame/error counters.
module tdm_demux #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNTW  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP0 = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] z0;
  logic [WIDTH-1:0] z1;
  logic             v0;
  logic             v1;
  logic             frame;
  logic             err;
  logic             lock;
  logic [CNTW-1:0]  fcnt;
  logic [CNTW-1:0]  ecnt;

  // Alignment FSM; every output is updated on the edge that accepts a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      z0    <= '0;
      z1    <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
      frame <= 1'b0;
      err   <= 1'b0;
      lock  <= 1'b0;
      fcnt  <= '0;
      ecnt  <= '0;
    end else begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      frame <= 1'b0;
      err   <= 1'b0;
      if (bus.en) begin
        unique case (state)
          HUNT: begin
            if (bus.sync) begin
              z0    <= bus.d;
              v0    <= 1'b1;
              state <= EXP1;
              lock  <= 1'b1;
            end
          end
          EXP1: begin
            if (bus.sync) begin
              // Early frame start: restart the frame on this ch0 sample.
              z0  <= bus.d;
              v0  <= 1'b1;
              err <= 1'b1;
              if (ecnt != '1) ecnt <= ecnt + CNTW'(1);
            end else begin
              z1    <= bus.d;
              v1    <= 1'b1;
              frame <= 1'b1;
              fcnt  <= fcnt + CNTW'(1);
              state <= EXP0;
            end
          end
          EXP0: begin
            if (bus.sync) begin
              z0    <= bus.d;
              v0    <= 1'b1;
              state <= EXP1;
            end else begin
              err   <= 1'b1;
              if (ecnt != '1) ecnt <= ecnt + CNTW'(1);
              state <= HUNT;
              lock  <= 1'b0;
            end
          end
          default: begin
            state <= HUNT;
            lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.z0    = z0;
  assign bus.z1    = z1;
  assign bus.v0    = v0;
  assign bus.v1    = v1;
  assign bus.frame = frame;
  assign bus.err   = err;
  assign bus.lock  = lock;
  assign bus.fcnt  = fcnt;
  assign bus.ecnt  = ecnt;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table, corner-case sequences and
// randomized traffic against a channel-sequence reference model.
module tb_tdm_demux;
  localparam int unsigned W = 4;
  localparam int unsigned C = 2;
  localparam int CMAX = (1 << C) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_if #(.WIDTH(W), .CNTW(C)) bus ();
  tdm_demux #(.WIDTH(W), .CNTW(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which channel was accepted last while aligned (-1 = not aligned).
  int last_ch;
  int m_z0, m_z1, m_v0, m_v1, m_fr, m_err;
  int frames, errors;

  function automatic void model_reset();
    last_ch = -1;
    m_z0 = 0; m_z1 = 0; m_v0 = 0; m_v1 = 0; m_fr = 0; m_err = 0;
    frames = 0; errors = 0;
  endfunction

  function automatic void model_step(input bit e, input bit s, input int dv);
    m_v0 = 0; m_v1 = 0; m_fr = 0; m_err = 0;
    if (!e) return;
    if (s) begin
      if (last_ch == 0) begin m_err = 1; errors++; end
      m_z0 = dv; m_v0 = 1; last_ch = 0;
    end else if (last_ch == 0) begin
      m_z1 = dv; m_v1 = 1; m_fr = 1; frames++; last_ch = 1;
    end else if (last_ch == 1) begin
      m_err = 1; errors++; last_ch = -1;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("z0", int'(bus.z0), m_z0);
    chk("z1", int'(bus.z1), m_z1);
    chk("v0", int'(bus.v0), m_v0);
    chk("v1", int'(bus.v1), m_v1);
    chk("frame", int'(bus.frame), m_fr);
    chk("err", int'(bus.err), m_err);
    chk("lock", int'(bus.lock), (last_ch >= 0) ? 1 : 0);
    chk("fcnt", int'(bus.fcnt), frames % (CMAX + 1));
    chk("ecnt", int'(bus.ecnt), (errors > CMAX) ? CMAX : errors);
  endtask

  task automatic step(input bit e, input bit s, input logic [W-1:0] dv);
    bus.en = e; bus.sync = s; bus.d = dv;
    @(posedge clk);
    #1;
    model_step(e, s, int'(dv));
    chk_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en; bit sync; logic [W-1:0] d;
    int z0; int z1; int v0; int v1; int fr; int er; int lk; int fc; int ec;
  } vec_t;
  vec_t tbl[11];

  initial begin
    bus.en = 1'b0; bus.sync = 1'b0; bus.d = '0;
    model_reset();
    //          en sync d     z0 z1 v0 v1 fr er lk fc ec
    tbl[0]  = '{1, 1, 4'h0,   0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 4'h1,   0, 1, 0, 1, 1, 0, 1, 1, 0};
    tbl[2]  = '{1, 1, 4'h1,   1, 1, 1, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 4'h0,   1, 0, 0, 1, 1, 0, 1, 2, 0};
    tbl[4]  = '{1, 1, 4'h1,   1, 0, 1, 0, 0, 0, 1, 2, 0};
    tbl[5]  = '{1, 1, 4'h0,   0, 0, 1, 0, 0, 1, 1, 2, 1};
    tbl[6]  = '{1, 0, 4'h1,   0, 1, 0, 1, 1, 0, 1, 3, 1};
    tbl[7]  = '{1, 0, 4'h1,   0, 1, 0, 0, 0, 1, 0, 3, 2};
    tbl[8]  = '{1, 0, 4'h0,   0, 1, 0, 0, 0, 0, 0, 3, 2};
    tbl[9]  = '{0, 1, 4'h1,   0, 1, 0, 0, 0, 0, 0, 3, 2};
    tbl[10] = '{1, 1, 4'h0,   0, 1, 1, 0, 0, 0, 1, 3, 2};

    // Reset state
    #2;
    chk("rst_z0", int'(bus.z0), 0);
    chk("rst_lock", int'(bus.lock), 0);
    chk("rst_fcnt", int'(bus.fcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: aligned stream, early sync, missing sync, idle sync
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en, tbl[i].sync, tbl[i].d);
      chk($sformatf("t%0d_z0", i), int'(bus.z0), tbl[i].z0);
      chk($sformatf("t%0d_z1", i), int'(bus.z1), tbl[i].z1);
      chk($sformatf("t%0d_v0", i), int'(bus.v0), tbl[i].v0);
      chk($sformatf("t%0d_v1", i), int'(bus.v1), tbl[i].v1);
      chk($sformatf("t%0d_frame", i), int'(bus.frame), tbl[i].fr);
      chk($sformatf("t%0d_err", i), int'(bus.err), tbl[i].er);
      chk($sformatf("t%0d_lock", i), int'(bus.lock), tbl[i].lk);
      chk($sformatf("t%0d_fcnt", i), int'(bus.fcnt), tbl[i].fc);
      chk($sformatf("t%0d_ecnt", i), int'(bus.ecnt), tbl[i].ec);
    end

    // Gapped EN: new ch0, idle gap with toggling data, then ch1
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b1, 4'h1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, g[0], (g[0]) ? 4'hF : 4'h0);
      chk("gap_z0", int'(bus.z0), 1);
      chk("gap_pulse", int'({bus.v0, bus.v1, bus.frame, bus.err}), 0);
    end
    step(1'b1, 1'b0, 4'h0);
    chk("gap_v1", int'(bus.v1), 1);
    chk("gap_frame", int'(bus.frame), 1);
    chk("gap_z0_hold", int'(bus.z0), 1);

    // Counter wrap and saturation
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step(1'b1, 1'b1, W'(f));
      step(1'b1, 1'b0, W'(f + 8));
    end
    chk("fcnt_wrap", int'(bus.fcnt), 1);
    step(1'b1, 1'b1, 4'h3);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, W'(k));
    chk("ecnt_sat", int'(bus.ecnt), 3);
    chk("ecnt_lock", int'(bus.lock), 1);

    // Asynchronous reset between ch0 and ch1 accepts
    step(1'b1, 1'b1, 4'h7);
    bus.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_z0", int'(bus.z0), 0);
    chk("arst_z1", int'(bus.z1), 0);
    chk("arst_v0", int'(bus.v0), 0);
    chk("arst_lock", int'(bus.lock), 0);
    chk("arst_fcnt", int'(bus.fcnt), 0);
    chk("arst_ecnt", int'(bus.ecnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h9);
    chk("hunt_no_err", int'(bus.err), 0);
    chk("hunt_z1", int'(bus.z1), 0);

    // Randomized traffic with occasional resets
    for (int r = 0; r < 600; r++) begin
      if (r % 150 == 149) do_reset();
      step(($urandom % 4) != 0, ($urandom % 3) == 0, W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 `mux`. It takes one shared data line carrying alternating channel-0/channel-1 samples plus a frame-sync marker. It steers each sample into a per-channel holding register with a valid strobe. It also tracks frame alignment, flags sync errors and counts frames and errors for lab-board display.

## Interface
- WIDTH, 1, bit width of each sample and of D/Z0/Z1
- CNTW, 8, width of FCNT and ECNT counters
- CLK  input  1  rising-edge clock, single clock domain
- RST_N  input  1  asynchronous, active-low reset
- D  input  WIDTH  multiplexed sample data
- EN  input  1  D holds a valid sample this cycle
- SYNC  input  1  qualified by EN: current sample is channel 0 (frame start)
- Z0  output  WIDTH  last channel-0 sample, registered
- Z1  output  WIDTH  last channel-1 sample, registered
- V0  output  1  one-cycle pulse: Z0 updated
- V1  output  1  one-cycle pulse: Z1 updated
- FRAME  output  1  one-cycle pulse: complete frame (ch0 then ch1) received
- ERR  output  1  one-cycle pulse: sync/alignment error detected
- LOCK  output  1  high while in EXP1 or EXP0 (aligned)
- FCNT  output  CNTW  completed-frame count, wraps
- ECNT  output  CNTW  error count, saturates at all-ones

## Operation
- States: HUNT (unaligned), EXP1 (ch0 taken, expecting ch1), EXP0 (frame done, expecting ch0).
- A sample is accepted only on a cycle with EN=1. With EN=0 the state and Z0/Z1 hold, and all pulses are 0. SYNC without EN is ignored.
- HUNT:
  - EN&SYNC: Z0<=D, V0, go EXP1.
  - EN&!SYNC: sample discarded, no ERR, stay in HUNT.
- EXP1:
  - EN&!SYNC: Z1<=D, V1, FRAME, FCNT+1, go EXP0.
  - EN&SYNC: early frame start. ERR, ECNT+1, Z0<=D, V0, stay in EXP1. The lost ch1 sample is not written.
- EXP0:
  - EN&SYNC: Z0<=D, V0, go EXP1.
  - EN&!SYNC: missing sync. ERR, ECNT+1, sample discarded, go HUNT.
- LOCK = (state != HUNT).
- FCNT wraps from 2^CNTW-1 to 0. ECNT stops at 2^CNTW-1.
- Z0/Z1 are written only on their accept cycle and never cleared except by reset.

## Timing
- All outputs are registered. Z0/Z1 and V0/V1/FRAME/ERR appear on the clock edge that samples the accepting EN cycle, i.e. 1-cycle latency, visible in the following cycle.
- Pulses are exactly one cycle wide. Back-to-back EN cycles give back-to-back pulses with no bubbles, throughput 1 sample/cycle.
- FRAME is coincident with V1. ERR may be coincident with V0 (EXP1 early-sync case).
- Reset (RST_N low, any time, asynchronous):
  - State HUNT.
  - Z0=Z1=0, V0=V1=FRAME=ERR=0, LOCK=0, FCNT=ECNT=0.
  - A frame in progress is abandoned and no pulse is emitted for it.
- Reset release: the first edge with RST_N high may accept a sample.

## Test plan
- Reset then aligned stream, WIDTH=1, EN=1 each cycle, D/SYNC = 0/1, 1/0, 1/1, 0/0 -> Z0=0,V0; Z1=1,V1,FRAME; Z0=1,V0; Z1=0,V1,FRAME; FCNT=2, ECNT=0, LOCK=1 from the first accept.
- Gapped EN: ch0 sample D=1, then 3 idle cycles with D toggling, then ch1 D=0 -> Z0 holds 1 through the gap, no pulses during the gap, V1+FRAME after ch1.
- Early sync in EXP1: SYNC samples D=1 then D=0 back-to-back -> ERR+V0 on the second, Z0=0, Z1 unchanged, ECNT=1, LOCK stays 1.
- Missing sync in EXP0: complete frame, then EN&!SYNC D=1 -> ERR, ECNT+1, Z0/Z1 unchanged, LOCK=0; subsequent non-SYNC samples are ignored until the next SYNC.
- Counters at CNTW=2: 5 frames -> FCNT=1 (wrap); 5 errors -> ECNT=3 (saturated).
- Async reset asserted mid-frame, between the ch0 and ch1 accepts -> all outputs are 0 immediately without waiting for CLK. After release, a ch1 sample without SYNC is discarded in HUNT with no ERR.
